iterative_muldiv_unit: RTL

//  Multi-cycle RV32M (Zmmul + divide) execution unit next to the single-cycle RV32I ALU in the EX stage.

---
 rtl/iterative_muldiv_unit_if.sv | 27 ++
 rtl/iterative_muldiv_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/iterative_muldiv_unit_if.sv
// Issue/writeback bundle between the EX stage and the multi-cycle M-extension unit.
interface iterative_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic [4:0]      rd_in;
  logic            kill;
  logic            stall_req;
  logic            busy;
  logic            done;
  logic            reg_wen;
  logic [XLEN-1:0] result;
  logic [4:0]      reg_waddr;

  modport master (
    output start, funct3, operand1, operand2, rd_in, kill,
    input  stall_req, busy, done, reg_wen, result, reg_waddr
  );

  modport slave (
    input  start, funct3, operand1, operand2, rd_in, kill,
    output stall_req, busy, done, reg_wen, result, reg_waddr
  );
endinterface

// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle RV32M unit: radix-2^MUL_BITS shift-add multiplier and restoring
// divider sharing one 2*XLEN accumulator. Operands are reduced to magnitudes
// at accept and the sign is applied when the result is committed.
module iterative_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  iterative_muldiv_unit_if.slave bus
);
  localparam int            CW      = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_CYC = CW'(XLEN / MUL_BITS);
  localparam logic [CW-1:0] DIV_CYC = CW'(XLEN);
  localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;     // {hi, lo}: product/multiplier or remainder/quotient
  logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode for the op presented this cycle.
  logic            sa, sb, neg1, neg2, div_zero, div_ovf, can_acc;
  logic [XLEN-1:0] mag1, mag2;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (bus.funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin sa = 1'b1; sb = 1'b1; end
      3'b010:                         sa = 1'b1;
      default:                        ;
    endcase
    neg1     = sa & bus.operand1[XLEN-1];
    neg2     = sb & bus.operand2[XLEN-1];
    mag1     = neg1 ? -bus.operand1 : bus.operand1;
    mag2     = neg2 ? -bus.operand2 : bus.operand2;
    div_zero = (bus.operand2 == '0);
    div_ovf  = sa & (bus.operand1 == SMIN) & (bus.operand2 == '1);
  end

  // One multiply step: add mcand * low multiplier digit into the upper half, shift right.
  logic [XLEN+MUL_BITS-1:0] mul_sum;
  logic [2*XLEN-1:0]        mul_next, prod_fix;

  always_comb begin
    mul_sum  = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]}
             + ({{MUL_BITS{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[MUL_BITS-1:0]});
    mul_next = {mul_sum, acc_q[XLEN-1:MUL_BITS]};
    prod_fix = neg_q ? -mul_next : mul_next;
  end

  // One restoring divide step: trial-subtract the divisor from the shifted remainder.
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_raw, div_fix;

  always_comb begin
    trial    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opb_q};
    div_next = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                           : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    div_raw  = f3_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    div_fix  = neg_q ? -div_raw : div_raw;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  // Next state: iterate, commit the result on the last step, accept in IDLE/DONE; kill wins.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    can_acc  = (state_q == S_IDLE) || (state_q == S_DONE);

    unique case (state_q)
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = (f3_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = div_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (can_acc && bus.start && !bus.kill) begin
      f3_d  = bus.funct3;
      rd_d  = bus.rd_in;
      opb_d = mag2;
      acc_d = {{XLEN{1'b0}}, mag1};
      // Remainder takes the dividend's sign; everything else the product of signs.
      neg_d = (bus.funct3[2] & bus.funct3[1]) ? neg1 : (neg1 ^ neg2);
      if (!bus.funct3[2]) begin
        state_d = S_MUL;
        cnt_d   = MUL_CYC;
      end else if (div_zero) begin
        state_d  = S_DONE;
        result_d = bus.funct3[1] ? bus.operand1 : '1;
      end else if (div_ovf) begin
        state_d  = S_DONE;
        result_d = bus.funct3[1] ? '0 : bus.operand1;
      end else begin
        state_d = S_DIV;
        cnt_d   = DIV_CYC;
      end
    end

    if (bus.kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // Handshake outputs; DONE's done pulse is not retracted by a same-cycle kill.
  always_comb begin
    bus.busy      = (state_q == S_MUL) || (state_q == S_DIV);
    bus.stall_req = (bus.start && can_acc && !bus.kill) || bus.busy;
    bus.done      = (state_q == S_DONE);
    bus.reg_wen   = bus.done && (rd_q != 5'd0);
    bus.result    = result_q;
    bus.reg_waddr = rd_q;
  end
endmodule
